// File: rtl/serial_rx_8n1.sv
// 8N1 asynchronous serial receiver with a one-byte holding register, ready/valid
// hand-off and sticky frame/overrun error flags.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | line idle, waiting for rx_s low (start edge)
// S_START | timing half a bit to re-check the start bit mid-bit
// S_DATA  | sampling the eight data bits, LSB first, mid-bit
// S_STOP  | sampling the stop bit; deliver byte or flag a framing error
// S_BREAK | stop bit was low; wait for the line to return high
module serial_rx_8n1 #(
    parameter int unsigned CLKS_PER_BIT = 174
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    input  logic       err_clr,
    output logic       busy
);

    localparam int unsigned CNT_W     = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF_BIT  = CLKS_PER_BIT / 2;
    localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_TC  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t           state;
    logic             rx_meta;
    logic             rx_s;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;

            // Defaults first; a delivery or error event later in this block overrides them.
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (err_clr) begin
                frame_err <= 1'b0;
                overrun   <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state   <= S_START;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end

                S_START: begin
                    if (bit_cnt == HALF_TC) begin
                        bit_cnt <= '0;
                        if (rx_s) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (bit_cnt == BIT_TC) begin
                        bit_cnt        <= '0;
                        shreg[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                S_STOP: begin
                    if (bit_cnt == BIT_TC) begin
                        bit_cnt <= '0;
                        if (rx_s) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            // A same-cycle transfer frees the holding register for the new byte.
                            if (!rx_valid || rx_ready) begin
                                rx_data  <= shreg;
                                rx_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            state     <= S_BREAK;
                            frame_err <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                S_BREAK: begin
                    if (rx_s) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_rx_8n1.sv
// Bench for serial_rx_8n1: a timeline model (sample times as offsets from the
// start edge) checked every cycle, plus directed frames with literal expectations.
module tb_serial_rx_8n1;

    localparam int C = 174;
    localparam int H = C / 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       err_clr;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;
    int edge_cnt = 0;
    int start_edge = 0;

    serial_rx_8n1 #(.CLKS_PER_BIT(C)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .err_clr  (err_clr),
        .busy     (busy)
    );

    always #25 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Model: line delayed two cycles, then frame events at fixed offsets from the start cycle.
    logic       m_s1, m_s2;
    int         m_mode;
    logic [7:0] m_byte;
    logic [7:0] m_data;
    logic       m_valid, m_ferr, m_ovr;

    initial begin
        int   n, t0, k, j;
        logic line, deliver, set_f, set_o;
        n = 0; t0 = 0;
        m_s1 = 1'b1; m_s2 = 1'b1; m_mode = 0; m_byte = 8'h00;
        m_data = 8'h00; m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_s1 = 1'b1; m_s2 = 1'b1; m_mode = 0;
                m_data = 8'h00; m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
            end else begin
                line = m_s2;
                deliver = 1'b0; set_f = 1'b0; set_o = 1'b0;
                case (m_mode)
                    0: if (!line) begin m_mode = 1; t0 = n; end
                    1: begin
                        k = n - t0;
                        if (k == H) begin
                            if (line) m_mode = 0;
                        end else if (k > H && ((k - H) % C) == 0) begin
                            j = (k - H) / C;
                            if (j <= 8) m_byte[3'(j - 1)] = line;
                            else if (line) begin deliver = 1'b1; m_mode = 0; end
                            else begin set_f = 1'b1; m_mode = 2; end
                        end
                    end
                    default: if (line) m_mode = 0;
                endcase
                if (deliver) begin
                    if (!m_valid || rx_ready) begin m_data = m_byte; m_valid = 1'b1; end
                    else set_o = 1'b1;
                end else if (m_valid && rx_ready) begin
                    m_valid = 1'b0;
                end
                m_ferr = set_f | (m_ferr & ~err_clr);
                m_ovr  = set_o | (m_ovr & ~err_clr);
                m_s2 = m_s1;
                m_s1 = rx;
            end
            n++;
        end
    end

    always @(posedge clk) begin
        #1;
        vectors++;
        if (rx_data !== m_data || rx_valid !== m_valid || frame_err !== m_ferr ||
            overrun !== m_ovr || busy !== (m_mode != 0)) begin
            miscompares++;
            $display("FAIL cycle %0d: dut data=%h valid=%b ferr=%b ovr=%b busy=%b, model data=%h valid=%b ferr=%b ovr=%b busy=%b",
                     edge_cnt, rx_data, rx_valid, frame_err, overrun, busy,
                     m_data, m_valid, m_ferr, m_ovr, (m_mode != 0));
        end
    end

    logic       collect = 1'b0;
    logic [7:0] xfer_q[$];
    always @(posedge clk) if (collect && rx_valid && rx_ready) xfer_q.push_back(rx_data);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic hold(input logic v, input int cycles);
        rx = v;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v);
        start_edge = edge_cnt;
        hold(1'b0, C);
        for (int i = 0; i < 8; i++) hold(b[i], C);
        hold(stop_v, C);
    endtask

    task automatic wait_valid(output int edge_at);
        bit got;
        got = 1'b0;
        edge_at = 0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(posedge clk);
            #1;
            if (rx_valid) begin got = 1'b1; edge_at = edge_cnt; end
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_valid: rx_valid did not rise within 3000 cycles");
        end
    endtask

    task automatic pulse_ready();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        int  e;
        bit  saw_busy;
        rst_n = 1'b0; rx = 1'b1; rx_ready = 1'b0; err_clr = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset_data", rx_data, 8'h00);
        chk("reset_valid", rx_valid, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_flags", {frame_err, overrun}, 2'b00);
        rst_n = 1'b1;
        hold(1'b1, 20);

        // single byte, consumer not ready
        e = 0;
        fork
            send_frame(8'h75, 1'b1);
            wait_valid(e);
        join
        chk("latency_0x75", e - start_edge, 1656);
        chk("data_0x75", rx_data, 8'h75);
        chk("model_data_0x75", m_data, 8'h75);
        chk("valid_0x75", rx_valid, 1'b1);
        chk("flags_0x75", {frame_err, overrun}, 2'b00);
        hold(1'b1, 10);
        pulse_ready();
        chk("consumed_0x75", rx_valid, 1'b0);

        // 40-cycle glitch is a false start
        hold(1'b0, 40);
        saw_busy = 1'b0;
        rx = 1'b1;
        for (int i = 0; i < 2 * C; i++) begin
            @(negedge clk);
            if (busy) saw_busy = 1'b1;
        end
        chk("glitch_busy_pulse", saw_busy, 1'b1);
        chk("glitch_valid", rx_valid, 1'b0);
        chk("glitch_busy_end", busy, 1'b0);
        chk("glitch_flags", {frame_err, overrun}, 2'b00);

        // framing error then good byte
        send_frame(8'hA3, 1'b0);
        hold(1'b1, C);
        chk("ferr_set", frame_err, 1'b1);
        chk("ferr_valid", rx_valid, 1'b0);
        chk("ferr_busy", busy, 1'b0);
        send_frame(8'h5C, 1'b1);
        hold(1'b1, 5);
        chk("data_0x5C", rx_data, 8'h5C);
        chk("valid_0x5C", rx_valid, 1'b1);
        chk("ferr_sticky", frame_err, 1'b1);
        pulse_ready();
        pulse_clr();
        chk("ferr_cleared", frame_err, 1'b0);

        // overrun on back-to-back bytes without consumer
        send_frame(8'h75, 1'b1);
        send_frame(8'hA3, 1'b1);
        hold(1'b1, 5);
        chk("ovr_data", rx_data, 8'h75);
        chk("model_ovr_data", m_data, 8'h75);
        chk("ovr_set", overrun, 1'b1);
        pulse_ready();
        chk("ovr_consumed", rx_valid, 1'b0);
        chk("ovr_sticky", overrun, 1'b1);
        pulse_clr();
        chk("ovr_cleared", overrun, 1'b0);

        // streaming with consumer always ready
        rx_ready = 1'b1;
        collect = 1'b1;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
        hold(1'b1, C);
        collect = 1'b0;
        rx_ready = 1'b0;
        chk("stream_count", xfer_q.size(), 3);
        if (xfer_q.size() == 3) begin
            chk("stream_b0", xfer_q[0], 8'h00);
            chk("stream_b1", xfer_q[1], 8'hFF);
            chk("stream_b2", xfer_q[2], 8'h55);
        end
        chk("stream_valid", rx_valid, 1'b0);
        chk("stream_flags", {frame_err, overrun}, 2'b00);

        // reset during data bit 4 of 0x75
        hold(1'b0, C);
        hold(1'b1, C); hold(1'b0, C); hold(1'b1, C); hold(1'b0, C);
        hold(1'b1, H);
        chk("midframe_busy", busy, 1'b1);
        rst_n = 1'b0;
        hold(1'b1, 3);
        chk("rst_data", rx_data, 8'h00);
        chk("rst_valid", rx_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_flags", {frame_err, overrun}, 2'b00);
        rst_n = 1'b1;
        hold(1'b1, 12 * C);
        chk("rst_no_byte", rx_valid, 1'b0);
        chk("rst_idle", busy, 1'b0);
        send_frame(8'h75, 1'b1);
        hold(1'b1, C);
        chk("post_rst_data", rx_data, 8'h75);
        chk("post_rst_valid", rx_valid, 1'b1);
        chk("post_rst_flags", {frame_err, overrun}, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
